// File: rtl/scs8hd_o311ai_bist.sv
// scs8hd_o311ai_bist
// Exhaustive 32-pattern self-test sequencer for the o311ai complex gate,
// Y = !((A1|A2|A3) & B1 & C1). It walks every input combination into the cell,
// samples Y after a programmable settle interval and keeps the mismatch count
// and the first failing pattern.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | after reset; stimulus 0, waiting for START
// RUN   | stepping patterns 0..31, settle down-counter then sample Y_IN
// DONE  | results frozen, stimulus back to 0; START begins a new run
//
// Only START and Y_IN are inputs. Every output comes straight from a
// flop, so no input reaches an output in the same cycle.

module scs8hd_o311ai_bist #(
    parameter int unsigned SETTLE       = 2,
    parameter bit          STOP_ON_FAIL = 1'b0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic       Y_IN,
    output logic       A1,
    output logic       A2,
    output logic       A3,
    output logic       B1,
    output logic       C1,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [5:0] FAIL_CNT,
    output logic [4:0] FIRST_FAIL
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE);
    localparam logic [4:0] PAT_LAST  = 5'd31;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic [3:0] settle_q;
    logic [4:0] pat_q;
    logic [5:0] fail_cnt_q;
    logic [4:0] first_fail_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;

    logic       start_go;
    logic       sample;
    logic       y_exp;
    logic       mismatch;
    logic       run_end;
    logic [5:0] fail_cnt_nxt;

    // Golden response of the current pattern and the per-cycle sequencing events
    always_comb begin
        y_exp        = ~((pat_q[0] | pat_q[1] | pat_q[2]) & pat_q[3] & pat_q[4]);
        start_go     = START && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        sample       = (state_q == ST_RUN) && (settle_q == 4'd0);
        mismatch     = sample && (Y_IN != y_exp);
        // STOP_ON_FAIL ends the run on the very sample that mismatched
        run_end      = sample && ((pat_q == PAT_LAST) || (STOP_ON_FAIL && mismatch));
        fail_cnt_nxt = fail_cnt_q + {5'd0, mismatch};
    end

    // Next-state decode; START is ignored while a run is in progress
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (START)   state_d = ST_RUN;
            ST_RUN:  if (run_end) state_d = ST_DONE;
            ST_DONE: if (START)   state_d = ST_RUN;
            default:              state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Settle down-counter: loaded per pattern, sample taken on terminal count 0
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            settle_q <= 4'd0;
        end else if (start_go) begin
            settle_q <= SETTLE_LD;
        end else if (state_q == ST_RUN) begin
            if (settle_q != 4'd0) begin
                settle_q <= settle_q - 4'd1;
            end else if (!run_end) begin
                settle_q <= SETTLE_LD;
            end
        end
    end

    // Pattern index doubles as the stimulus register; it is zero outside RUN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pat_q <= 5'd0;
        end else if (start_go) begin
            pat_q <= 5'd0;
        end else if (sample) begin
            pat_q <= run_end ? 5'd0 : (pat_q + 5'd1);
        end
    end

    // BUSY/DONE status flags
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (start_go) begin
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else if (run_end) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
        end
    end

    // Result accumulation; cleared on the START edge, frozen once DONE
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            fail_cnt_q   <= 6'd0;
            first_fail_q <= 5'd0;
            pass_q       <= 1'b0;
        end else if (start_go) begin
            fail_cnt_q   <= 6'd0;
            first_fail_q <= 5'd0;
            pass_q       <= 1'b0;
        end else begin
            if (mismatch) begin
                fail_cnt_q <= fail_cnt_nxt;
                if (fail_cnt_q == 6'd0) begin
                    first_fail_q <= pat_q;
                end
            end
            // PASS is registered alongside the final count so it is stable through DONE
            if (run_end) begin
                pass_q <= (fail_cnt_nxt == 6'd0);
            end
        end
    end

    assign {C1, B1, A3, A2, A1} = pat_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign PASS       = pass_q;
    assign FAIL_CNT   = fail_cnt_q;
    assign FIRST_FAIL = first_fail_q;

endmodule

// File: tb/tb_scs8hd_o311ai_bist.sv
// Testbench for scs8hd_o311ai_bist: three instances (SETTLE=2, SETTLE=0, and
// SETTLE=2 with STOP_ON_FAIL) driven by a truth-table model of the cell under test.
// Expected results come from a pattern-walk reference model pushed into a
// scoreboard queue; a negedge monitor pops and compares.

module tb_scs8hd_o311ai_bist;

    localparam int N = 3;

    typedef struct {
        int inst;
        int e0;
        int edone;
        int fc;
        int ff;
        int pass;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   start_v;
    logic [N-1:0]   y_v;
    logic [N-1:0]   a1_v, a2_v, a3_v, b1_v, c1_v;
    logic [N-1:0]   busy_v, done_v, pass_v;
    logic [5:0]     fcnt  [N];
    logic [4:0]     ffail [N];
    logic [4:0]     stim  [N];
    logic [31:0]    tt    [N];

    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sbq[$];

    logic [N-1:0] done_prev = '0;
    logic [N-1:0] last_ok   = '0;
    int           last_fc   [N];
    int           last_ff   [N];
    int           last_pass [N];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    scs8hd_o311ai_bist #(.SETTLE(2), .STOP_ON_FAIL(1'b0)) u_dut0 (
        .CLK(clk), .RESET(rst), .START(start_v[0]), .Y_IN(y_v[0]),
        .A1(a1_v[0]), .A2(a2_v[0]), .A3(a3_v[0]), .B1(b1_v[0]), .C1(c1_v[0]),
        .BUSY(busy_v[0]), .DONE(done_v[0]), .PASS(pass_v[0]),
        .FAIL_CNT(fcnt[0]), .FIRST_FAIL(ffail[0])
    );

    scs8hd_o311ai_bist #(.SETTLE(0), .STOP_ON_FAIL(1'b0)) u_dut1 (
        .CLK(clk), .RESET(rst), .START(start_v[1]), .Y_IN(y_v[1]),
        .A1(a1_v[1]), .A2(a2_v[1]), .A3(a3_v[1]), .B1(b1_v[1]), .C1(c1_v[1]),
        .BUSY(busy_v[1]), .DONE(done_v[1]), .PASS(pass_v[1]),
        .FAIL_CNT(fcnt[1]), .FIRST_FAIL(ffail[1])
    );

    scs8hd_o311ai_bist #(.SETTLE(2), .STOP_ON_FAIL(1'b1)) u_dut2 (
        .CLK(clk), .RESET(rst), .START(start_v[2]), .Y_IN(y_v[2]),
        .A1(a1_v[2]), .A2(a2_v[2]), .A3(a3_v[2]), .B1(b1_v[2]), .C1(c1_v[2]),
        .BUSY(busy_v[2]), .DONE(done_v[2]), .PASS(pass_v[2]),
        .FAIL_CNT(fcnt[2]), .FIRST_FAIL(ffail[2])
    );

    // Cell under test modelled as a 32-entry truth table indexed by the stimulus
    for (genvar g = 0; g < N; g++) begin : g_cell
        assign stim[g] = {c1_v[g], b1_v[g], a3_v[g], a2_v[g], a1_v[g]};
        assign y_v[g]  = tt[g][stim[g]];
    end

    function automatic int settle_of(input int inst);
        return (inst == 1) ? 0 : 2;
    endfunction

    function automatic bit stop_of(input int inst);
        return (inst == 2);
    endfunction

    // The o311ai output is low only for the seven patterns 25..31
    function automatic bit golden(input int p);
        return (p >= 25) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic [31:0] tbl_ideal();
        logic [31:0] t;
        for (int p = 0; p < 32; p++) t[p] = golden(p);
        return t;
    endfunction

    // Faulty cell lacking the A3 term: low when B1=C1=1 and A1 or A2 is set
    function automatic logic [31:0] tbl_no_a3();
        logic [31:0] t;
        for (int p = 0; p < 32; p++) t[p] = !((p >= 24) && ((p % 4) != 0));
        return t;
    endfunction

    function automatic exp_t model(input int inst, input logic [31:0] tbl, input int e0);
        exp_t e;
        int   last;
        e.inst = inst;
        e.e0   = e0;
        e.fc   = 0;
        e.ff   = 0;
        last   = 31;
        for (int p = 0; p < 32; p++) begin
            if (tbl[p] != golden(p)) begin
                if (e.fc == 0) e.ff = p;
                e.fc++;
                if (stop_of(inst)) begin
                    last = p;
                    break;
                end
            end
        end
        e.edone = e0 + (last + 1) * (settle_of(inst) + 1);
        e.pass  = (e.fc == 0) ? 1 : 0;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_zero(input int i, input string tag);
        chk({tag, "_stim"},  int'(stim[i]),   0);
        chk({tag, "_busy"},  int'(busy_v[i]), 0);
        chk({tag, "_done"},  int'(done_v[i]), 0);
        chk({tag, "_pass"},  int'(pass_v[i]), 0);
        chk({tag, "_fcnt"},  int'(fcnt[i]),   0);
        chk({tag, "_ffail"}, int'(ffail[i]),  0);
    endtask

    // Monitor: per-cycle stepping checks during a run, result compare on DONE rise
    always @(negedge clk) begin
        bit   rise;
        bit   mine;
        int   k;
        exp_t e;
        for (int i = 0; i < N; i++) begin
            rise = (done_v[i] === 1'b1) && (done_prev[i] !== 1'b1);
            mine = (sbq.size() > 0) && (sbq[0].inst == i);
            if (mine && cyc >= sbq[0].e0 && cyc < sbq[0].edone) begin
                k = cyc - sbq[0].e0;
                chk("busy_in_run", int'(busy_v[i]), 1);
                chk("done_in_run", int'(done_v[i]), 0);
                chk("stim_step", int'(stim[i]), k / (settle_of(i) + 1));
                if (k == 0) begin
                    chk("fcnt_cleared", int'(fcnt[i]), 0);
                    chk("ffail_cleared", int'(ffail[i]), 0);
                end
            end
            if (rise) begin
                if (mine) begin
                    e = sbq.pop_front();
                    chk("done_edge", cyc - e.e0, e.edone - e.e0);
                    chk("busy_at_done", int'(busy_v[i]), 0);
                    chk("stim_at_done", int'(stim[i]), 0);
                    chk("fail_cnt", int'(fcnt[i]), e.fc);
                    chk("first_fail", int'(ffail[i]), e.ff);
                    chk("pass", int'(pass_v[i]), e.pass);
                    last_fc[i]   <= e.fc;
                    last_ff[i]   <= e.ff;
                    last_pass[i] <= e.pass;
                    last_ok[i]   <= 1'b1;
                end else begin
                    chk("unexpected_done", int'(done_v[i]), 0);
                end
            end else if (mine && cyc >= sbq[0].edone) begin
                chk("done_timeout", int'(done_v[i]), 1);
                void'(sbq.pop_front());
            end else if (done_v[i] === 1'b1 && last_ok[i]) begin
                chk("hold_fail_cnt", int'(fcnt[i]), last_fc[i]);
                chk("hold_first_fail", int'(ffail[i]), last_ff[i]);
                chk("hold_pass", int'(pass_v[i]), last_pass[i]);
                chk("hold_stim", int'(stim[i]), 0);
            end
            done_prev[i] <= done_v[i];
        end
    end

    task automatic run(input int inst, input logic [31:0] tbl, input int hold_cyc);
        exp_t e;
        int   budget;
        @(negedge clk);
        tt[inst]      = tbl;
        start_v[inst] = 1'b1;
        e = model(inst, tbl, cyc + 1);
        sbq.push_back(e);
        repeat (hold_cyc) @(negedge clk);
        start_v[inst] = 1'b0;
        budget = 0;
        while (sbq.size() != 0 && budget < 400) begin
            @(negedge clk);
            budget++;
        end
        if (sbq.size() != 0) begin
            chk("run_bound", sbq.size(), 0);
            sbq.delete();
        end
    endtask

    task automatic reset_mid_run();
        exp_t e;
        @(negedge clk);
        tt[0]      = tbl_ideal();
        start_v[0] = 1'b1;
        e = model(0, tt[0], cyc + 1);
        sbq.push_back(e);
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (30) @(negedge clk);
        chk("stim_before_reset", int'(stim[0]), 10);
        sbq.delete();
        #1 rst = 1'b1;
        #1;
        chk_zero(0, "async_reset");
        chk("async_reset_done1", int'(done_v[1]), 0);
        chk("async_reset_done2", int'(done_v[2]), 0);
        #1 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] m;
        int          inst;
        rst     = 1'b1;
        start_v = '0;
        for (int i = 0; i < N; i++) tt[i] = tbl_ideal();
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) chk_zero(i, "reset");
        rst = 1'b0;

        // SETTLE=2, full runs
        run(0, tbl_ideal(), 1);
        run(0, 32'hFFFF_FFFF, 1);
        run(0, 32'h0000_0000, 1);
        run(0, tbl_no_a3(), 1);
        run(0, tbl_ideal(), 50);
        reset_mid_run();
        run(0, tbl_ideal(), 1);

        // STOP_ON_FAIL
        run(2, 32'h0000_0000, 1);
        run(2, tbl_no_a3(), 1);
        run(2, tbl_ideal(), 1);

        // SETTLE=0, restarting from DONE each time
        run(1, tbl_ideal(), 1);
        run(1, 32'hFFFF_FFFF, 1);
        run(1, 32'h0000_0000, 1);

        // Random sparse faults on random instances
        for (int r = 0; r < 8; r++) begin
            inst = $urandom_range(0, N - 1);
            m    = $urandom & $urandom & $urandom;
            run(inst, tbl_ideal() ^ m, 1);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
